if_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits on the other side of the program-counter register: it reads the current PC and writes back the next PC (sequential +4 or redirect target).
- Issues in-order requests to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- Flushes in-flight work on branch/jump redirect.

---
 rtl/if_fetch_unit_if.sv | 36 +++
 rtl/if_fetch_unit.sv | 97 +++++++++
 tb/tb_if_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: PC register link, instruction-memory request/response,
// decode handshake, redirect and the sticky protocol-error flag.
interface if_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic               pc_wr_en;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               proto_err;

  modport master (
    input  pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect, redirect_pc,
    output pc_next, pc_wr_en, imem_req_valid, imem_addr, if_valid, if_instr,
           if_pc, proto_err
  );

  modport slave (
    output pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect, redirect_pc,
    input  pc_next, pc_wr_en, imem_req_valid, imem_addr, if_valid, if_instr,
           if_pc, proto_err
  );
endinterface

// File: rtl/if_fetch_unit.sv
// In-order instruction fetch front end: issues PC-addressed memory requests,
// buffers responses with their PCs for decode, and flushes on redirect.
module if_fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32,
  parameter int INSTR_W    = 32
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 2;

  logic [CNT_W-1:0]   pend_cnt_reg, buf_cnt_reg, drop_cnt_reg;
  logic [PTR_W-1:0]   pend_wr_reg, pend_rd_reg, buf_wr_reg, buf_rd_reg;
  logic               proto_err_reg;
  logic [ADDR_W-1:0]  pend_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  buf_pc_mem [FIFO_DEPTH];
  logic [INSTR_W-1:0] buf_instr_mem [FIFO_DEPTH];

  logic [OCC_W-1:0] occupancy;
  logic credit, req_valid, accept, pop;
  logic rsp_drop, rsp_take, rsp_err, rsp_used;

  // Stale responses still hold credit so they can never overrun the buffer.
  assign occupancy = OCC_W'(pend_cnt_reg) + OCC_W'(buf_cnt_reg) + OCC_W'(drop_cnt_reg);
  assign credit    = occupancy < OCC_W'(FIFO_DEPTH);
  assign req_valid = credit & ~bus.redirect & ~rst;
  assign accept    = req_valid & bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid & (drop_cnt_reg != '0);
  assign rsp_take = bus.imem_rsp_valid & (drop_cnt_reg == '0) & (pend_cnt_reg != '0);
  assign rsp_err  = bus.imem_rsp_valid & (drop_cnt_reg == '0) & (pend_cnt_reg == '0);
  assign rsp_used = rsp_drop | rsp_take;
  assign pop      = (buf_cnt_reg != '0) & bus.id_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = bus.pc;
  assign bus.pc_wr_en       = ~rst & (bus.redirect | accept);
  assign bus.pc_next        = bus.redirect ? bus.redirect_pc :
                              accept       ? bus.pc + ADDR_W'(4) : bus.pc;
  assign bus.if_valid       = buf_cnt_reg != '0;
  assign bus.if_instr       = buf_instr_mem[buf_rd_reg];
  assign bus.if_pc          = buf_pc_mem[buf_rd_reg];
  assign bus.proto_err      = proto_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_reg  <= '0;
      buf_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
      pend_wr_reg   <= '0;
      pend_rd_reg   <= '0;
      buf_wr_reg    <= '0;
      buf_rd_reg    <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (rsp_err)
        proto_err_reg <= 1'b1;
      if (bus.redirect) begin
        // Everything still in flight becomes stale; a response arriving now
        // is already accounted for whether it was dropped or consumed.
        pend_cnt_reg <= '0;
        buf_cnt_reg  <= '0;
        pend_wr_reg  <= '0;
        pend_rd_reg  <= '0;
        buf_wr_reg   <= '0;
        buf_rd_reg   <= '0;
        drop_cnt_reg <= drop_cnt_reg + pend_cnt_reg - CNT_W'(rsp_used);
      end else begin
        if (accept)
          pend_wr_reg <= pend_wr_reg + PTR_W'(1);
        if (rsp_take) begin
          pend_rd_reg <= pend_rd_reg + PTR_W'(1);
          buf_wr_reg  <= buf_wr_reg + PTR_W'(1);
        end
        if (pop)
          buf_rd_reg <= buf_rd_reg + PTR_W'(1);
        pend_cnt_reg <= pend_cnt_reg + CNT_W'(accept) - CNT_W'(rsp_take);
        buf_cnt_reg  <= buf_cnt_reg + CNT_W'(rsp_take) - CNT_W'(pop);
        drop_cnt_reg <= drop_cnt_reg - CNT_W'(rsp_drop);
      end
    end
  end

  // Storage needs no reset: counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (accept)
      pend_mem[pend_wr_reg] <= bus.pc;
    if (rsp_take) begin
      buf_pc_mem[buf_wr_reg]    <= pend_mem[pend_rd_reg];
      buf_instr_mem[buf_wr_reg] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based model of outstanding requests and decode entries.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  if_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  if_fetch_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        mq[$];
  ent_t        eq[$];
  logic [31:0] pc_reg;
  bit          perr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] new_pc);
    rst                = 1'b1;
    bus.redirect       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.pc             = new_pc;
    #1;
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_pc_wr_en", 32'(bus.pc_wr_en), 32'd0);
    check("rst_proto_err", 32'(bus.proto_err), 32'd0);
    mq.delete();
    eq.delete();
    perr   = 1'b0;
    pc_reg = new_pc;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at the falling edge, check 1 time unit later, then
  // advance the model to what the rising edge should produce.
  task automatic step(input bit rdy, input bit idr, input bit redir,
                      input logic [31:0] rpc, input bit rsp_en, input bit unsol);
    bit          rsp_fire, exp_req, exp_acc, exp_wr, exp_ifv;
    logic [31:0] data, exp_next;
    req_t        e;
    ent_t        n;
    rsp_fire = (rsp_en && mq.size() != 0) || unsol;
    data     = (mq.size() != 0) ? instr_of(mq[0].addr) : $urandom;
    bus.pc             = pc_reg;
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    bus.redirect       = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = rsp_fire;
    bus.imem_rsp_data  = data;
    #1;
    exp_req  = (mq.size() + eq.size() < DEPTH) && !redir;
    exp_acc  = exp_req && rdy;
    exp_wr   = redir || exp_acc;
    exp_next = redir ? rpc : (exp_acc ? pc_reg + 32'd4 : pc_reg);
    exp_ifv  = eq.size() != 0;
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    check("imem_addr", bus.imem_addr, pc_reg);
    check("pc_wr_en", 32'(bus.pc_wr_en), 32'(exp_wr));
    check("pc_next", bus.pc_next, exp_next);
    check("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
    check("proto_err", 32'(bus.proto_err), 32'(perr));
    if (exp_ifv) begin
      check("if_pc", bus.if_pc, eq[0].pc);
      check("if_instr", bus.if_instr, eq[0].instr);
    end
    if (exp_ifv && idr)
      void'(eq.pop_front());
    if (rsp_fire) begin
      if (mq.size() == 0) begin
        perr = 1'b1;
      end else begin
        e = mq.pop_front();
        if (!e.stale && !redir) begin
          n.pc    = e.addr;
          n.instr = data;
          eq.push_back(n);
        end
      end
    end
    if (redir) begin
      eq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
    end
    if (exp_acc) begin
      e.addr  = pc_reg;
      e.stale = 1'b0;
      mq.push_back(e);
    end
    if (exp_wr)
      pc_reg = exp_next;
    @(negedge clk);
  endtask

  initial begin
    bus.pc             = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    pc_reg             = '0;
    perr               = 1'b0;
    @(negedge clk);

    // Streaming from 0 with single-cycle memory and an always-ready decoder.
    do_reset(32'h0);
    repeat (8) step(1, 1, 0, 0, 1, 0);

    // Decode stall fills the buffer, then resumes.
    repeat (5) step(1, 0, 0, 0, 1, 0);
    repeat (5) step(1, 1, 0, 0, 1, 0);

    // Memory not ready for three cycles.
    repeat (3) step(0, 1, 0, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 1, 0);

    // Redirect to 0x100 with two requests outstanding.
    do_reset(32'h40);
    repeat (2) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h100, 0, 0);
    repeat (8) step(1, 1, 0, 0, 1, 0);

    // Redirect coinciding with the only outstanding response.
    do_reset(32'h200);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h300, 1, 0);
    repeat (5) step(1, 1, 0, 0, 1, 0);

    // Back-to-back redirects.
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h500, 0, 0);
    step(1, 1, 1, 32'h600, 1, 0);
    repeat (6) step(1, 1, 0, 0, 1, 0);

    // Unsolicited response is sticky; PC wraps at the top of the space.
    do_reset(32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 1, 0);
    do_reset(32'h0);
    repeat (2) step(1, 1, 0, 0, 1, 0);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset({$urandom_range(0, 255), 2'b00});
      end else begin
        step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
             {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ($urandom % 2) != 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
